// File: rtl/serializador_pkg.sv
// Shared state encoding and default sizing for the serializador bit-serial transmitter.
package serializador_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

   localparam int SER_WORD_W     = 8;
   localparam int SER_DEPTH      = 4;
   localparam int SER_GAP_CYCLES = 2;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO that buffers parallel words ahead of the serializer.
// The head word is always presented on rdata_o; a pop simply advances the read pointer.
module word_fifo
   import serializador_pkg::*;
#(
   parameter int WORD_W = SER_WORD_W,
   parameter int DEPTH  = SER_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WORD_W-1:0]        wdata_i,
   output logic [WORD_W-1:0]        rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              do_push, do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Storage is never reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/serializador.sv
// Bit-serial transmitter: buffers words, then replays each MSB-first on data_out/write_out,
// holding off new frames while the downstream deserializer reports busy.
module serializador
   import serializador_pkg::*;
#(
   parameter int WORD_W     = SER_WORD_W,
   parameter int DEPTH      = SER_DEPTH,
   parameter int GAP_CYCLES = SER_GAP_CYCLES
) (
   input  logic                     clock_100KHz,
   input  logic                     reset,
   input  logic [WORD_W-1:0]        word_in,
   input  logic                     word_valid_in,
   output logic                     word_ready_out,
   input  logic                     busy_in,
   output logic                     data_out,
   output logic                     write_out,
   output logic [$clog2(DEPTH):0]   level_out,
   output logic [7:0]               words_sent_out
);

   localparam int CW = $clog2(WORD_W) + 1;
   localparam int GW = $clog2(GAP_CYCLES) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   ser_state_t        state_q;
   logic [WORD_W-2:0] shift_q;
   logic [CW-1:0]     bit_cnt_q;
   logic [GW-1:0]     gap_cnt_q;
   logic              data_q, write_q;
   logic [7:0]        sent_q;

   logic [WORD_W-1:0] fifo_rdata;
   logic              fifo_full, fifo_empty, pop;

   assign pop            = (state_q == IDLE) && !fifo_empty && !busy_in;
   assign word_ready_out = !fifo_full;
   assign data_out       = data_q;
   assign write_out      = write_q;
   assign words_sent_out = sent_q;

   word_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i   (clock_100KHz),
      .rst_ni  (reset),
      .push_i  (word_valid_in),
      .pop_i   (pop),
      .wdata_i (word_in),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_out)
   );

   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         data_q    <= 1'b0;
         write_q   <= 1'b0;
         sent_q    <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  write_q   <= 1'b1;
                  data_q    <= fifo_rdata[WORD_W-1];
                  bit_cnt_q <= CW'(1);
                  state_q   <= SHIFT;
               end else begin
                  write_q <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_cnt_q == LAST_BIT) begin
                  write_q   <= 1'b0;
                  sent_q    <= sent_q + 8'd1;
                  gap_cnt_q <= GAP_LOAD;
                  state_q   <= GAP;
               end else begin
                  data_q    <= shift_q[WORD_W-2];
                  bit_cnt_q <= bit_cnt_q + CW'(1);
               end
            end
            GAP: begin
               write_q <= 1'b0;
               if (gap_cnt_q == '0) state_q <= IDLE;
               else                 gap_cnt_q <= gap_cnt_q - GW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The MSB leaves directly from the FIFO head, so only the remaining bits are kept.
   always_ff @(posedge clock_100KHz) begin
      if (pop)                    shift_q <= fifo_rdata[WORD_W-2:0];
      else if (state_q == SHIFT)  shift_q <= shift_q << 1;
   end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: frame timing, FIFO full/throttle, busy handling, async reset, wrap.
module tb_serializador;

   logic       clk;
   logic       rst_n;
   logic [7:0] word;
   logic       valid;
   logic       ready;
   logic       busy;
   logic       data;
   logic       wr;
   logic [2:0] level;
   logic [7:0] sent;

   int checks   = 0;
   int failures = 0;

   serializador dut (
      .clock_100KHz   (clk),
      .reset          (rst_n),
      .word_in        (word),
      .word_valid_in  (valid),
      .word_ready_out (ready),
      .busy_in        (busy),
      .data_out       (data),
      .write_out      (wr),
      .level_out      (level),
      .words_sent_out (sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after the edge where bit 0 became visible; returns 11 cycles later.
   task automatic expect_frame(input logic [7:0] w, input int busy_at, input logic [7:0] exp_sent);
      for (int k = 0; k < 8; k++) begin
         chk("frame_wr", wr, 1'b1);
         chk("frame_bit", data, w[7-k]);
         if (k == busy_at) busy = 1'b1;
         tick();
      end
      for (int g = 0; g < 3; g++) begin
         chk("gap_wr", wr, 1'b0);
         if (g == 0) chk("frame_sent", sent, exp_sent);
         tick();
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_wr", wr, 1'b0);
      chk("rst_level", level, 3'd0);
      chk("rst_sent", sent, 8'd0);
      #2 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      word  = 8'h00;
      valid = 1'b0;
      busy  = 1'b0;

      // Reset then idle
      #22 rst_n = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         chk("idle", {wr, level, ready, sent}, {1'b0, 3'd0, 1'b1, 8'd0});
         tick();
      end

      // Single word 0xA5
      word = 8'hA5; valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("a5_no_bypass", wr, 1'b0);
      chk("a5_level", level, 3'd1);
      tick();
      expect_frame(8'hA5, -1, 8'd1);
      chk("a5_level_after", level, 3'd0);

      // Fill under busy, ignore fifth push, then drain four frames back-to-back
      do_reset();
      busy = 1'b1;
      word = 8'h3C; valid = 1'b1; tick();
      word = 8'hC3; tick();
      word = 8'hFF; tick();
      word = 8'h00; tick();
      chk("full_level", level, 3'd4);
      chk("full_ready", ready, 1'b0);
      chk("full_wr", wr, 1'b0);
      word = 8'h55; tick();
      valid = 1'b0;
      chk("fifth_ignored", level, 3'd4);
      busy = 1'b0;
      tick();
      expect_frame(8'h3C, -1, 8'd1);
      expect_frame(8'hC3, -1, 8'd2);
      expect_frame(8'hFF, -1, 8'd3);
      expect_frame(8'h00, -1, 8'd4);
      for (int i = 0; i < 6; i++) begin
         chk("drained_wr", wr, 1'b0);
         chk("drained_level", level, 3'd0);
         tick();
      end

      // busy rises on bit 3 of 0x81; the queued 0x42 waits for busy to fall
      word = 8'h81; valid = 1'b1; tick();
      word = 8'h42; tick();
      valid = 1'b0;
      expect_frame(8'h81, 3, 8'd5);
      for (int i = 0; i < 4; i++) begin
         chk("held_wr", wr, 1'b0);
         chk("held_level", level, 3'd1);
         tick();
      end
      busy = 1'b0;
      chk("release_wr", wr, 1'b0);
      tick();
      expect_frame(8'h42, -1, 8'd6);

      // Reset during bit 5 with two words queued
      word = 8'hF0; valid = 1'b1; tick();
      word = 8'h0F; tick();
      word = 8'hAA; tick();
      valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("pre_rst_wr", wr, 1'b1);
      chk("pre_rst_bit5", data, 1'b0);
      chk("pre_rst_level", level, 3'd2);
      chk("pre_rst_sent", sent, 8'd6);
      do_reset();
      for (int i = 0; i < 15; i++) begin
         chk("post_rst", {wr, level, sent}, {1'b0, 3'd0, 8'd0});
         tick();
      end

      // 256 words with a push on every pop edge; level stays at 1 throughout
      word = 8'h00; valid = 1'b1; tick();
      valid = 1'b0;
      for (int j = 0; j < 255; j++) begin
         word = 8'(j + 1); valid = 1'b1;
         tick();
         valid = 1'b0;
         chk("pushpop_level", level, 3'd1);
         chk("pushpop_wr", wr, 1'b1);
         if (j < 254) for (int i = 0; i < 10; i++) tick();
      end
      for (int i = 0; i < 11; i++) tick();
      chk("last_level", level, 3'd0);
      chk("last_wr", wr, 1'b1);
      chk("last_bit0", data, 1'b1);
      for (int i = 0; i < 7; i++) tick();
      chk("sent_255", sent, 8'd255);
      tick();
      chk("sent_wrap", sent, 8'd0);
      chk("wrap_wr", wr, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
